// File: rtl/npc_pkg.sv
// Shared core-wide types: register index and machine word widths, plus the
// writeback requester numbering used by the register-file write arbiter.
package npc_pkg;

  localparam int NPC_REG_AW = 5;
  localparam int NPC_XLEN   = 32;

  typedef logic [NPC_REG_AW-1:0] reg_idx_t;
  typedef logic [NPC_XLEN-1:0]   xword_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_CSR = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from a rotating pointer,
// which moves just past the winner whenever the grant is taken.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Walk the scan order backwards so the last hit assigned is the first one
  // reached from the pointer.
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = '0;
    win   = ptr;
    sum   = '0;
    idx   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: round-robin writeback selection with a
// one-cycle output register, plus the per-register busy scoreboard for decode.
module rf_wb_arbiter
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = NPC_REG_AW,
  parameter int DATA_WIDTH = NPC_XLEN,
  parameter int NUM_REQ    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  input  logic                          flush,
  output logic                          rf_wen,
  output logic [ADDR_WIDTH-1:0]         rf_waddr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  output logic [2**ADDR_WIDTH-1:0]      busy
);

  logic [NUM_REQ-1:0]      arb_req;
  logic [NUM_REQ-1:0]      grant;
  logic                    handshake;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [2**ADDR_WIDTH-1:0] busy_next;

  // Flush suppresses arbitration entirely; reset masks the grant outright.
  assign arb_req   = req_valid & {NUM_REQ{~flush}};
  assign req_ready = grant & {NUM_REQ{rst_n}};
  assign handshake = |(req_valid & req_ready);

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (handshake),
    .grant   (grant)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Clear on write, then set on issue (set wins), then flush overrides all.
  always_comb begin
    busy_next = busy;
    if (rf_wen) busy_next[rf_waddr] = 1'b0;
    if (issue_valid && (issue_rd != '0) && !flush) busy_next[issue_rd] = 1'b1;
    if (flush) busy_next = '0;
    busy_next[0] = 1'b0;
  end

  // Writes to x0 are accepted from the requester but never reach the file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= '0;
    end else begin
      rf_wen <= 1'b0;
      if (handshake) begin
        rf_wen   <= (sel_addr != '0);
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, rotation, scoreboard set/clear,
// x0 writes and flush, each against hand-computed expected values.
module tb_rf_wb_arbiter;
  import npc_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            flush;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [2**AW-1:0] busy;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .flush      (flush),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  logic [NR-1:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [AW-1:0] exp_a [4] = '{5'd5, 5'd6, 5'd7, 5'd5};
  logic [DW-1:0] exp_d [4] = '{32'hA, 32'hB, 32'hC, 32'hA};

  initial begin
    rst_n       = 1'b0;
    req_valid   = 3'b111;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    flush       = 1'b0;
    set_req(int'(WB_ALU), 5'd5, 32'hA);
    set_req(int'(WB_LSU), 5'd6, 32'hB);
    set_req(int'(WB_CSR), 5'd7, 32'hC);

    // 1. Reset with all requesters valid
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_wen", 64'(rf_wen), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'b001);

    // 2. Round-robin rotation, one write per cycle
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(exp_g[k]));
      step();
      check($sformatf("rr_wen%0d", k), 64'(rf_wen), 64'd1);
      check($sformatf("rr_waddr%0d", k), 64'(rf_waddr), 64'(exp_a[k]));
      check($sformatf("rr_wdata%0d", k), 64'(rf_wdata), 64'(exp_d[k]));
    end
    req_valid = '0;
    step();
    check("rr_idle_wen", 64'(rf_wen), 64'd0);
    check("rr_idle_hold", 64'(rf_waddr), 64'd5);

    // 3. Scoreboard set then clear by a write (pointer now at requester 1)
    issue_valid = 1'b1;
    issue_rd    = 5'd10;
    step();
    issue_valid = 1'b0;
    check("sb_set", 64'(busy), 64'(32'h1 << 10));
    step();
    check("sb_hold", 64'(busy), 64'(32'h1 << 10));
    set_req(1, 5'd10, 32'h1234);
    req_valid = 3'b010;
    #1;
    check("sb_grant", 64'(req_ready), 64'b010);
    step();
    req_valid = '0;
    check("sb_wen", 64'(rf_wen), 64'd1);
    check("sb_waddr", 64'(rf_waddr), 64'd10);
    check("sb_wdata", 64'(rf_wdata), 64'h1234);
    check("sb_still_busy", 64'(busy), 64'(32'h1 << 10));
    step();
    check("sb_clear", 64'(busy), 64'd0);
    check("sb_wen_off", 64'(rf_wen), 64'd0);

    // 4. Same-edge clear and set on x3 (pointer at 2, scan reaches 0)
    set_req(0, 5'd3, 32'h33);
    req_valid = 3'b001;
    #1;
    check("ss_grant", 64'(req_ready), 64'b001);
    step();
    req_valid   = '0;
    check("ss_wen", 64'(rf_wen), 64'd1);
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    step();
    issue_valid = 1'b0;
    check("ss_set_wins", 64'(busy), 64'(32'h1 << 3));

    // 5. x0: no scoreboard bit, accepted write but no enable
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    set_req(2, 5'd0, 32'hFFFF_FFFF);
    req_valid = 3'b100;
    #1;
    check("x0_ready", 64'(req_ready), 64'b100);
    step();
    issue_valid = 1'b0;
    req_valid   = '0;
    check("x0_busy", 64'(busy), 64'(32'h1 << 3));
    check("x0_wen", 64'(rf_wen), 64'd0);
    step();
    check("x0_wen_next", 64'(rf_wen), 64'd0);

    // 6. Flush clears the scoreboard and blocks grants for one cycle
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    step();
    issue_rd    = 5'd9;
    step();
    issue_valid = 1'b0;
    check("fl_pre_busy", 64'(busy), 64'((32'h1 << 3) | (32'h1 << 4) | (32'h1 << 9)));
    set_req(0, 5'd12, 32'h55);
    req_valid = 3'b001;
    flush     = 1'b1;
    #1;
    check("fl_ready", 64'(req_ready), 64'd0);
    step();
    flush = 1'b0;
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_wen", 64'(rf_wen), 64'd0);
    #1;
    check("fl_regrant", 64'(req_ready), 64'b001);
    step();
    req_valid = '0;
    check("fl_wen_after", 64'(rf_wen), 64'd1);
    check("fl_waddr_after", 64'(rf_waddr), 64'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
